// File: rtl/cpu_ula_pkg.sv
// Shared definitions for the ALU issue block: opcodes, FSM encodings and instruction fields.
// The opcode values are shared with the ALU itself.
package cpu_ula_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SUBI = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int RD_HI  = 12;
   localparam int RD_LO  = 10;
   localparam int RS1_HI = 9;
   localparam int RS1_LO = 7;
   localparam int RS2_HI = 2;
   localparam int RS2_LO = 0;
   localparam int IMM_HI = 6;
   localparam int IMM_LO = 0;

   localparam int TIMEOUT_CYCLES_DEF = 15;

   // Opcodes 110/111 are illegal, 000 is NOP; everything else goes to the ALU.
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op != OP_NOP) && !(op[2] && op[1]);
   endfunction

   function automatic logic is_illegal_op(input logic [2:0] op);
      return op[2] && op[1];
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 8x16 register file, r0 hard-wired to zero. Two read ports capture on cap_en,
// one write port, plus a combinational debug read.
import cpu_ula_pkg::*;

module cpu_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        cap_en,
   input  logic [2:0]  ra1,
   input  logic [2:0]  ra2,
   output logic [15:0] rd1,
   output logic [15:0] rd2,
   input  logic        we,
   input  logic [2:0]  wa,
   input  logic [15:0] wd,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   logic [15:0] mem [8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
      end else if (we && (wa != 3'd0)) begin
         mem[wa] <= wd;
      end
   end

   // mem[0] is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1 <= 16'h0000;
         rd2 <= 16'h0000;
      end else if (cap_en) begin
         rd1 <= mem[ra1];
         rd2 <= mem[ra2];
      end
   end

   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/cpu_ula_issue.sv
// ALU issue block: accepts an instruction, issues it to the ALU for one cycle,
// waits for done and writes back. Optional WAIT timeout under ULA_TIMEOUT_EN.
import cpu_ula_pkg::*;

module cpu_ula_issue #(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [2:0]  ula_op_code,
   output logic [15:0] ula_src1,
   output logic [15:0] ula_src2,
   input  logic [15:0] ula_result,
   input  logic        ula_done,
   output logic        wb_valid,
   output logic [2:0]  wb_addr,
   output logic [15:0] wb_data,
   output logic        illegal,
   output logic        timeout_err,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
);

   // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
   logic [1:0]  state;
   logic [2:0]  op_q;
   logic [2:0]  rd_q;
   logic        imm_sel;
   logic [6:0]  imm_q;
   logic [15:0] rd1;
   logic [15:0] rd2;
   logic        accept;
   logic        to_hit;
   logic [2:0]  opcode;

   assign opcode      = instr[OPC_HI:OPC_LO];
   assign instr_ready = (state == ST_IDLE);
   assign accept      = instr_ready && instr_valid;

   cpu_regfile u_rf (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (accept && is_alu_op(opcode)),
      .ra1      (instr[RS1_HI:RS1_LO]),
      .ra2      (instr[RS2_HI:RS2_LO]),
      .rd1      (rd1),
      .rd2      (rd2),
      .we       ((state == ST_WAIT) && ula_done),
      .wa       (rd_q),
      .wd       (ula_result),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

`ifdef ULA_TIMEOUT_EN
   logic [3:0] wait_cnt;

   assign to_hit = (state == ST_WAIT) && !ula_done && (wait_cnt == 4'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= 4'd0;
         timeout_err <= 1'b0;
      end else begin
         if (state == ST_ISSUE) wait_cnt <= 4'd0;
         else if (state == ST_WAIT) wait_cnt <= wait_cnt + 4'd1;
         if (to_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_q    <= OP_NOP;
         rd_q    <= 3'd0;
         imm_sel <= 1'b0;
         imm_q   <= 7'd0;
         wb_addr <= 3'd0;
         wb_data <= 16'h0000;
         illegal <= 1'b0;
      end else begin
         illegal <= accept && is_illegal_op(opcode);
         case (state)
            ST_IDLE: begin
               if (accept && is_alu_op(opcode)) begin
                  op_q    <= opcode;
                  rd_q    <= instr[RD_HI:RD_LO];
                  imm_sel <= (opcode == OP_ADDI) || (opcode == OP_SUBI);
                  imm_q   <= instr[IMM_HI:IMM_LO];
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (ula_done) begin
                  wb_addr <= rd_q;
                  wb_data <= ula_result;
                  state   <= ST_WB;
               end else if (to_hit) begin
                  state <= ST_IDLE;
               end
            end
            ST_WB:   state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The opcode is only presented in ISSUE so the ALU sees exactly one trigger.
   assign ula_op_code = (state == ST_ISSUE) ? op_q : OP_NOP;
   assign ula_src1    = rd1;
   assign ula_src2    = imm_sel ? {9'b0, imm_q} : rd2;
   assign wb_valid    = (state == ST_WB);

endmodule

// File: tb/tb_cpu_ula_issue.sv
// Directed bench for cpu_ula_issue with a small behavioural ALU (2-cycle latency,
// sign-magnitude immediates). Define ULA_TIMEOUT_EN to also exercise the timeout.
module tb_cpu_ula_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = 16'h0000;
   logic [2:0]  ula_op_code;
   logic [15:0] ula_src1;
   logic [15:0] ula_src2;
   logic [15:0] ula_result = 16'h0000;
   logic        ula_done;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        illegal;
   logic        timeout_err;
   logic [2:0]  dbg_addr = 3'd0;
   logic [15:0] dbg_data;

   logic alu_en = 1'b1;
   logic alu_done = 1'b0;
   logic force_done = 1'b0;
   int   checks = 0;
   int   errors = 0;

   assign ula_done = alu_done | force_done;

   cpu_ula_issue dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .ula_op_code (ula_op_code),
      .ula_src1    (ula_src1),
      .ula_src2    (ula_src2),
      .ula_result  (ula_result),
      .ula_done    (ula_done),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .illegal     (illegal),
      .timeout_err (timeout_err),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: samples during the ISSUE cycle, done pulses two cycles later.
   always begin
      logic [15:0] a, b, r;
      @(negedge clk);
      if (alu_en && ula_op_code != 3'b000) begin
         a = ula_src1;
         b = ula_src2;
         case (ula_op_code)
            3'b001:  r = a + b;
            3'b010:  r = b[6] ? a - {10'b0, b[5:0]} : a + {10'b0, b[5:0]};
            3'b011:  r = a - b;
            3'b100:  r = b[6] ? a + {10'b0, b[5:0]} : a - {10'b0, b[5:0]};
            3'b101:  r = a * b;
            default: r = 16'h0000;
         endcase
         @(posedge clk);
         @(posedge clk); #1;
         ula_result = r;
         alu_done   = 1'b1;
         @(posedge clk); #1;
         alu_done   = 1'b0;
      end
   end

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [6:0] low);
      return {op, rd, rs1, low};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Called #1 after a rising edge; returns #1 after the accept edge (cycle E0+1).
   task automatic send(input logic [15:0] w);
      int n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL send_ready: instr_ready=%b required 1", instr_ready);
      end
      instr       = w;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      instr       = 16'h0000;
   endtask

   task automatic run_alu(input logic [15:0] w, input logic [2:0] exp_addr,
                          input logic [15:0] exp_data, input string name);
      int cyc = 1;
      int ops = 0;
      send(w);
      while (wb_valid !== 1'b1 && cyc < 12) begin
         if (ula_op_code !== 3'b000) ops++;
         step();
         cyc++;
      end
      checks++;
      if (cyc != 4 || ops != 1) begin
         errors++;
         $display("FAIL %s_timing: wb at E0+%0d with %0d issue cycles, required E0+4 with 1", name, cyc, ops);
      end
      checks++;
      if (wb_addr !== exp_addr || wb_data !== exp_data) begin
         errors++;
         $display("FAIL %s_wb: addr=%0d data=%h required addr=%0d data=%h", name, wb_addr, wb_data, exp_addr, exp_data);
      end
      step();
      checks++;
      if (instr_ready !== 1'b1 || wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_return: ready=%b wb_valid=%b required 1/0", name, instr_ready, wb_valid);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (instr_ready !== 1'b1 || ula_op_code !== 3'b000 || ula_src1 !== 16'h0 || ula_src2 !== 16'h0 ||
          wb_valid !== 1'b0 || wb_addr !== 3'd0 || wb_data !== 16'h0 || illegal !== 1'b0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: ready=%b op=%b s1=%h s2=%h wbv=%b wba=%0d wbd=%h ill=%b to=%b required 1,0,0,0,0,0,0,0,0",
                  name, instr_ready, ula_op_code, ula_src1, ula_src2, wb_valid, wb_addr, wb_data, illegal, timeout_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset_outputs");
      dbg_addr = 3'd3;
      #1;
      checks++;
      if (dbg_data !== 16'h0) begin
         errors++;
         $display("FAIL reset_rf: r3=%h required 0000", dbg_data);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_add();
      run_alu(enc(3'b010, 3'd1, 3'd0, 7'd5), 3'd1, 16'd5, "addi_r1");
      run_alu(enc(3'b010, 3'd2, 3'd0, 7'd7), 3'd2, 16'd7, "addi_r2");
      send(enc(3'b001, 3'd3, 3'd1, 7'd2));
      checks++;
      if (ula_op_code !== 3'b001 || ula_src1 !== 16'd5 || ula_src2 !== 16'd7) begin
         errors++;
         $display("FAIL add_issue: op=%b s1=%h s2=%h required 001/0005/0007", ula_op_code, ula_src1, ula_src2);
      end
      step();
      checks++;
      if (ula_op_code !== 3'b000 || instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL add_wait: op=%b ready=%b required 000/0", ula_op_code, instr_ready);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_early_wb: wb_valid=%b required 0", wb_valid);
      end
      step();
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 16'd12) begin
         errors++;
         $display("FAIL add_wb: v=%b addr=%0d data=%h required 1/3/000c", wb_valid, wb_addr, wb_data);
      end
      step();
      dbg_addr = 3'd3;
      #1;
      checks++;
      if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || dbg_data !== 16'd12) begin
         errors++;
         $display("FAIL add_done: ready=%b wbv=%b r3=%h required 1/0/000c", instr_ready, wb_valid, dbg_data);
      end
   endtask

   task automatic test_addi_neg();
      send(enc(3'b010, 3'd1, 3'd0, 7'b1000011));
      checks++;
      if (ula_src2 !== 16'h0043 || ula_src1 !== 16'h0000) begin
         errors++;
         $display("FAIL addi_neg_src: s1=%h s2=%h required 0000/0043", ula_src1, ula_src2);
      end
      repeat (3) step();
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 3'd1 || wb_data !== 16'hFFFD) begin
         errors++;
         $display("FAIL addi_neg_wb: v=%b addr=%0d data=%h required 1/1/fffd", wb_valid, wb_addr, wb_data);
      end
      step();
   endtask

   task automatic test_mul();
      run_alu(enc(3'b010, 3'd1, 3'd0, 7'd63), 3'd1, 16'd63, "mul_b0");
      run_alu(enc(3'b001, 3'd1, 3'd1, 7'd1), 3'd1, 16'd126, "mul_b1");
      run_alu(enc(3'b001, 3'd1, 3'd1, 7'd1), 3'd1, 16'd252, "mul_b2");
      run_alu(enc(3'b010, 3'd1, 3'd1, 7'd48), 3'd1, 16'd300, "mul_b3");
      run_alu(enc(3'b001, 3'd2, 3'd1, 7'd0), 3'd2, 16'd300, "mul_b4");
      run_alu(enc(3'b101, 3'd4, 3'd1, 7'd2), 3'd4, 16'h5F90, "mul");
   endtask

   task automatic test_r0_write();
      run_alu(enc(3'b001, 3'd0, 3'd1, 7'd1), 3'd0, 16'h0258, "r0_write");
      dbg_addr = 3'd0;
      #1;
      checks++;
      if (dbg_data !== 16'h0000) begin
         errors++;
         $display("FAIL r0_read: r0=%h required 0000", dbg_data);
      end
   endtask

   task automatic test_back_to_back();
      run_alu(enc(3'b001, 3'd5, 3'd4, 7'd1), 3'd5, 16'h60BC, "b2b_add");
      run_alu(enc(3'b011, 3'd6, 3'd5, 7'd4), 3'd6, 16'h012C, "b2b_sub");
   endtask

   task automatic test_illegal();
      logic [2:0] ops [2];
      ops[0] = 3'b111;
      ops[1] = 3'b110;
      for (int i = 0; i < 2; i++) begin
         send(enc(ops[i], 3'd2, 3'd1, 7'd3));
         checks++;
         if (illegal !== 1'b1 || ula_op_code !== 3'b000 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_%b: ill=%b op=%b ready=%b required 1/000/1", ops[i], illegal, ula_op_code, instr_ready);
         end
         step();
         checks++;
         if (illegal !== 1'b0 || ula_op_code !== 3'b000) begin
            errors++;
            $display("FAIL illegal_%b_pulse: ill=%b op=%b required 0/000", ops[i], illegal, ula_op_code);
         end
      end
   endtask

   task automatic test_nop_and_stray_done();
      int bad = 0;
      send(enc(3'b000, 3'd6, 3'd1, 7'd1));
      force_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || ula_op_code !== 3'b000) bad++;
         step();
      end
      force_done = 1'b0;
      dbg_addr = 3'd6;
      #1;
      checks++;
      if (bad != 0 || dbg_data !== 16'h012C || wb_data !== 16'h012C) begin
         errors++;
         $display("FAIL nop_idle: bad_cycles=%0d r6=%h wb_data=%h required 0/012c/012c", bad, dbg_data, wb_data);
      end
   endtask

`ifdef ULA_TIMEOUT_EN
   task automatic test_timeout();
      int cyc = 1;
      int wb_seen = 0;
      alu_en = 1'b0;
      send(enc(3'b010, 3'd7, 3'd0, 7'd9));
      while (timeout_err !== 1'b1 && cyc < 40) begin
         if (wb_valid === 1'b1) wb_seen++;
         step();
         cyc++;
      end
      dbg_addr = 3'd7;
      #1;
      checks++;
      if (cyc != 17 || wb_seen != 0 || instr_ready !== 1'b1 || dbg_data !== 16'h0) begin
         errors++;
         $display("FAIL timeout: at E0+%0d wb=%0d ready=%b r7=%h required E0+17/0/1/0000", cyc, wb_seen, instr_ready, dbg_data);
      end
      alu_en = 1'b1;
   endtask
`endif

   task automatic test_reset_mid_wait();
      int wb_seen = 0;
      alu_en = 1'b0;
      send(enc(3'b010, 3'd7, 3'd0, 7'd9));
      repeat (2) step();
      #2;
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_mid_wait");
      dbg_addr = 3'd1;
      #1;
      checks++;
      if (dbg_data !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid_wait_rf: r1=%h required 0000", dbg_data);
      end
      @(negedge clk);
      rst    = 1'b0;
      alu_en = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         if (wb_valid === 1'b1) wb_seen++;
         step();
      end
      checks++;
      if (wb_seen != 0) begin
         errors++;
         $display("FAIL rst_no_wb: wb pulses=%0d required 0", wb_seen);
      end
      run_alu(enc(3'b100, 3'd2, 3'd0, 7'b1000100), 3'd2, 16'd4, "post_rst_subi");
   endtask

   initial begin
      test_reset();
      test_add();
      test_addi_neg();
      test_mul();
      test_r0_write();
      test_back_to_back();
      test_illegal();
      test_nop_and_stray_done();
`ifdef ULA_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
